// File: rtl/clock_pkg.sv
// clock_pkg: shared mode enum, BCD limits and hour-range constants for the digital clock.
// Defining H12_EN selects the 12-hour range (12, 01..11) instead of 00..23.
package clock_pkg;
  typedef enum logic [1:0] {RUN = 2'd0, SET_HOUR = 2'd1, SET_MIN = 2'd2} mode_e;
  localparam logic [7:0] BCD_59 = 8'h59;
  localparam logic [7:0] BCD_23 = 8'h23;
  localparam logic [7:0] BCD_12 = 8'h12;
  localparam logic [7:0] BCD_11 = 8'h11;
`ifdef H12_EN
  localparam logic [7:0] HOUR_MAX  = BCD_12;
  localparam logic [7:0] HOUR_WRAP = 8'h01;
`else
  localparam logic [7:0] HOUR_MAX  = BCD_23;
  localparam logic [7:0] HOUR_WRAP = 8'h00;
`endif
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    return v[3:0] == 4'd9 ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
  endfunction
  // Hour 00 is not a legal 12-hour value, so it maps to 12 at reset.
  function automatic logic [7:0] hour_init(input logic [7:0] h);
`ifdef H12_EN
    return h == 8'h00 ? BCD_12 : h;
`else
    return h;
`endif
  endfunction
endpackage

// File: rtl/bcd_mod_counter.sv
// bcd_mod_counter: two-digit packed-BCD counter; MAX steps to WRAP, wrap flags that step combinationally.
module bcd_mod_counter
  import clock_pkg::*;
#(
  parameter logic [7:0] MAX  = BCD_59,
  parameter logic [7:0] WRAP = 8'h00,
  parameter logic [7:0] INIT = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [7:0] q,
  output logic       wrap
);
  logic [7:0] q_q, q_d;
  always_comb begin
    wrap = inc && !load && q_q == MAX;
    q_d  = load ? load_val : !inc ? q_q : q_q == MAX ? WRAP : bcd_inc(q_q);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) q_q <= INIT;
    else     q_q <= q_d;
  assign q = q_q;
endmodule

// File: rtl/time_counter.sv
// time_counter: BCD hh:mm:ss timekeeper with button-driven set mode.
// Defining H12_EN builds the 12-hour variant with a pm flag.
module time_counter
  import clock_pkg::*;
#(
  parameter logic [7:0] START_HOUR = 8'h00,
  parameter logic [7:0] START_MIN  = 8'h00
) (
  input  logic       in_clk,
  input  logic       rst,
  input  logic       sec_tick,
  input  logic       mode_btn,
  input  logic       inc_btn,
  output logic [7:0] sec_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] hour_bcd,
  output logic [1:0] mode,
  output logic       min_tick,
  output logic       hour_tick,
  output logic       pm
);
  mode_e mode_q, mode_d;
  logic  min_tick_q, min_tick_d, hour_tick_q, hour_tick_d;
  logic  run, edit, sec_inc, min_inc, hour_inc, sec_clr;
  logic  sec_wrap, min_wrap, unused_hour_wrap;
  // mode_btn wins over inc_btn; a RUN tick still lands in the cycle that leaves RUN.
  assign run      = mode_q == RUN;
  assign edit     = inc_btn && !mode_btn;
  assign sec_inc  = run && sec_tick;
  assign min_inc  = run ? sec_wrap : mode_q == SET_MIN && edit;
  assign hour_inc = run ? min_wrap : mode_q == SET_HOUR && edit;
  assign sec_clr  = mode_q == SET_MIN && mode_btn;
  always_comb begin
    mode_d      = !mode_btn ? mode_q : mode_q == RUN ? SET_HOUR : mode_q == SET_HOUR ? SET_MIN : RUN;
    min_tick_d  = run && sec_wrap;
    hour_tick_d = run && min_wrap;
  end
  always_ff @(posedge in_clk or posedge rst)
    if (rst) begin
      mode_q      <= RUN;
      min_tick_q  <= 1'b0;
      hour_tick_q <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      min_tick_q  <= min_tick_d;
      hour_tick_q <= hour_tick_d;
    end
  bcd_mod_counter #(.MAX(BCD_59), .WRAP(8'h00), .INIT(8'h00)) u_sec (
    .clk(in_clk), .rst(rst), .inc(sec_inc), .load(sec_clr), .load_val(8'h00),
    .q(sec_bcd), .wrap(sec_wrap)
  );
  bcd_mod_counter #(.MAX(BCD_59), .WRAP(8'h00), .INIT(START_MIN)) u_min (
    .clk(in_clk), .rst(rst), .inc(min_inc), .load(1'b0), .load_val(8'h00),
    .q(min_bcd), .wrap(min_wrap)
  );
  bcd_mod_counter #(.MAX(HOUR_MAX), .WRAP(HOUR_WRAP), .INIT(hour_init(START_HOUR))) u_hour (
    .clk(in_clk), .rst(rst), .inc(hour_inc), .load(1'b0), .load_val(8'h00),
    .q(hour_bcd), .wrap(unused_hour_wrap)
  );
`ifdef H12_EN
  // pm flips whenever hours step 11 -> 12, whether by carry or by the set button.
  logic pm_q, pm_d;
  always_comb pm_d = pm_q ^ (hour_inc && hour_bcd == BCD_11);
  always_ff @(posedge in_clk or posedge rst)
    if (rst) pm_q <= 1'b0;
    else     pm_q <= pm_d;
  assign pm = pm_q;
`else
  assign pm = 1'b0;
`endif
  assign mode      = mode_q;
  assign min_tick  = min_tick_q;
  assign hour_tick = hour_tick_q;
endmodule

// File: tb/tb_time_counter.sv
// tb_time_counter: directed self-checking bench for time_counter (24-hour build, H12_EN build when defined).
module tb_time_counter;
  logic       in_clk = 1'b0, rst = 1'b1, sec_tick = 1'b0, mode_btn = 1'b0, inc_btn = 1'b0;
  logic [7:0] sec_bcd, min_bcd, hour_bcd;
  logic [1:0] mode;
  logic       min_tick, hour_tick, pm;
  int         checks = 0, failures = 0;
`ifdef H12_EN
  localparam logic [7:0] H0 = 8'h12;
`else
  localparam logic [7:0] H0 = 8'h00;
`endif

  time_counter dut (
    .in_clk(in_clk), .rst(rst), .sec_tick(sec_tick), .mode_btn(mode_btn), .inc_btn(inc_btn),
    .sec_bcd(sec_bcd), .min_bcd(min_bcd), .hour_bcd(hour_bcd), .mode(mode),
    .min_tick(min_tick), .hour_tick(hour_tick), .pm(pm)
  );

  always #5 in_clk = ~in_clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic time_is(input string tag, input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    chk({tag, "_hour"}, hour_bcd, h);
    chk({tag, "_min"}, min_bcd, m);
    chk({tag, "_sec"}, sec_bcd, s);
  endtask

  task automatic flags_is(input string tag, input logic [1:0] md, input logic mt, input logic ht);
    chk({tag, "_mode"}, {6'd0, mode}, {6'd0, md});
    chk({tag, "_min_tick"}, {7'd0, min_tick}, {7'd0, mt});
    chk({tag, "_hour_tick"}, {7'd0, hour_tick}, {7'd0, ht});
  endtask

  // One clock with the given pulses; outputs are sampled 1 time unit after the edge.
  task automatic cyc(input logic s, input logic m, input logic i);
    sec_tick = s;
    mode_btn = m;
    inc_btn  = i;
    @(posedge in_clk);
    #1;
    sec_tick = 1'b0;
    mode_btn = 1'b0;
    inc_btn  = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) cyc(1'b1, 1'b0, 1'b0);
  endtask

  task automatic incs(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    repeat (2) @(posedge in_clk);
    #1;
    rst = 1'b0;
    time_is("reset", H0, 8'h00, 8'h00);
    flags_is("reset", 2'd0, 1'b0, 1'b0);
    chk("reset_pm", {7'd0, pm}, 8'h00);
`ifdef H12_EN
    cyc(1'b0, 1'b1, 1'b0);
    incs(1);
    chk("h12_set_12_01", hour_bcd, 8'h01);
    chk("h12_set_12_01_pm", {7'd0, pm}, 8'h00);
    incs(10);
    chk("h12_set_11", hour_bcd, 8'h11);
    cyc(1'b0, 1'b1, 1'b0);
    incs(59);
    cyc(1'b0, 1'b1, 1'b0);
    ticks(59);
    time_is("h12_115959", 8'h11, 8'h59, 8'h59);
    chk("h12_115959_pm", {7'd0, pm}, 8'h00);
    ticks(1);
    time_is("h12_noon", 8'h12, 8'h00, 8'h00);
    chk("h12_noon_pm", {7'd0, pm}, 8'h01);
    flags_is("h12_noon", 2'd0, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    incs(59);
    cyc(1'b0, 1'b1, 1'b0);
    ticks(59);
    time_is("h12_125959", 8'h12, 8'h59, 8'h59);
    ticks(1);
    time_is("h12_one", 8'h01, 8'h00, 8'h00);
    chk("h12_one_pm", {7'd0, pm}, 8'h01);
    cyc(1'b0, 1'b1, 1'b0);
    incs(10);
    chk("h12_set_11b_pm", {7'd0, pm}, 8'h01);
    incs(1);
    chk("h12_set_11_12", hour_bcd, 8'h12);
    chk("h12_set_11_12_pm", {7'd0, pm}, 8'h00);
    incs(1);
    chk("h12_set_12_01b", hour_bcd, 8'h01);
    chk("h12_set_12_01b_pm", {7'd0, pm}, 8'h00);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    chk("h12_back_run", {6'd0, mode}, 8'h00);
`else
    ticks(59);
    time_is("t59", 8'h00, 8'h00, 8'h59);
    chk("t59_min_tick", {7'd0, min_tick}, 8'h00);
    ticks(1);
    time_is("t60", 8'h00, 8'h01, 8'h00);
    flags_is("t60", 2'd0, 1'b1, 1'b0);
    ticks(1);
    time_is("t61", 8'h00, 8'h01, 8'h01);
    chk("t61_min_tick", {7'd0, min_tick}, 8'h00);
    cyc(1'b0, 1'b1, 1'b0);
    chk("enter_set_hour", {6'd0, mode}, 8'h01);
    incs(23);
    time_is("preload_hour", 8'h23, 8'h01, 8'h01);
    cyc(1'b0, 1'b1, 1'b0);
    chk("enter_set_min", {6'd0, mode}, 8'h02);
    incs(58);
    time_is("preload_min", 8'h23, 8'h59, 8'h01);
    cyc(1'b0, 1'b1, 1'b0);
    time_is("preload_exit", 8'h23, 8'h59, 8'h00);
    chk("preload_exit_mode", {6'd0, mode}, 8'h00);
    ticks(58);
    ticks(1);
    time_is("t235959", 8'h23, 8'h59, 8'h59);
    flags_is("t235959", 2'd0, 1'b0, 1'b0);
    ticks(1);
    time_is("midnight", 8'h00, 8'h00, 8'h00);
    flags_is("midnight", 2'd0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    flags_is("midnight_after", 2'd0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    incs(24);
    time_is("set_hour_wrap", 8'h00, 8'h00, 8'h00);
    incs(1);
    time_is("set_hour_25", 8'h01, 8'h00, 8'h00);
    ticks(100);
    time_is("frozen", 8'h01, 8'h00, 8'h00);
    flags_is("frozen", 2'd1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1);
    time_is("mode_beats_inc", 8'h01, 8'h00, 8'h00);
    chk("mode_beats_inc_mode", {6'd0, mode}, 8'h02);
    incs(59);
    chk("set_min_59", min_bcd, 8'h59);
    incs(1);
    time_is("set_min_wrap", 8'h01, 8'h00, 8'h00);
    chk("set_min_wrap_min_tick", {7'd0, min_tick}, 8'h00);
    cyc(1'b0, 1'b1, 1'b0);
    chk("back_run", {6'd0, mode}, 8'h00);
    ticks(36);
    cyc(1'b1, 1'b1, 1'b0);
    chk("tick_and_mode_sec", sec_bcd, 8'h37);
    chk("tick_and_mode_mode", {6'd0, mode}, 8'h01);
    cyc(1'b0, 1'b1, 1'b0);
    chk("set_min_sec_held", sec_bcd, 8'h37);
    cyc(1'b0, 1'b1, 1'b0);
    time_is("exit_clears_sec", 8'h01, 8'h00, 8'h00);
    chk("exit_clears_sec_mode", {6'd0, mode}, 8'h00);
`endif
    cyc(1'b0, 1'b1, 1'b0);
    incs(2);
    cyc(1'b0, 1'b1, 1'b0);
    incs(3);
    chk("pre_rst_min", min_bcd, 8'h03);
    #2 rst = 1'b1;
    #1;
    time_is("async_rst", H0, 8'h00, 8'h00);
    flags_is("async_rst", 2'd0, 1'b0, 1'b0);
    @(negedge in_clk);
    rst = 1'b0;
    ticks(1);
    time_is("after_rst", H0, 8'h00, 8'h01);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/time_counter.md
# time_counter

Timekeeping stage directly downstream of the frequency divider in the digital clock. It consumes the divider's one-second tick as a single-cycle enable in the system clock domain. It maintains seconds, minutes and hours as packed BCD and provides a button-driven set mode. Its registered BCD outputs feed the seven-segment display driver.

## Interface
- START_HOUR, default 8'h00: BCD hour loaded on reset; must be a legal hour for the compiled mode.
- START_MIN, default 8'h00: BCD minute loaded on reset; 8'h00..8'h59.

Ports:
- in_clk  input  1  system clock; the only clock in the block.
- rst  input  1  reset, asynchronous, active-high.
- sec_tick  input  1  one-cycle pulse at 1 Hz, synchronous to in_clk.
- mode_btn  input  1  debounced one-cycle pulse; advances the set-mode FSM.
- inc_btn  input  1  debounced one-cycle pulse; increments the selected field in set mode.
- sec_bcd  output  8  seconds, BCD 00..59.
- min_bcd  output  8  minutes, BCD 00..59.
- hour_bcd  output  8  hours, BCD; range depends on configuration.
- mode  output  2  FSM state: 0 RUN, 1 SET_HOUR, 2 SET_MIN.
- min_tick  output  1  one-cycle pulse when seconds wrap 59->00 in RUN.
- hour_tick  output  1  one-cycle pulse when minutes wrap 59->00 in RUN.
- pm  output  1  afternoon flag; constant 0 unless H12_EN is defined.

## Operation
- FSM states: RUN -> SET_HOUR -> SET_MIN -> RUN, each transition on mode_btn. No other transitions.
- RUN behaviour:
  - sec_tick increments seconds.
  - 59 wraps to 00, pulses min_tick and increments minutes.
  - Minute 59 wrap pulses hour_tick and increments hours.
  - 23:59:59 -> 00:00:00 in one tick.
- SET_HOUR / SET_MIN behaviour:
  - sec_tick is ignored and time is frozen.
  - inc_btn increments only the selected field, with wrap and no carry: hour 23->00, minute 59->00.
  - min_tick and hour_tick stay low.
- Leaving SET_MIN (SET_MIN -> RUN) clears seconds to 00.
- Simultaneous events:
  - mode_btn and inc_btn in the same cycle: mode_btn wins, inc_btn is dropped.
  - mode_btn and sec_tick in RUN in the same cycle: the tick is applied first, then the state moves to SET_HOUR.
- BCD arithmetic:
  - A low digit of 9 rolls to 0 and increments the high digit.
  - Illegal BCD never appears on outputs.
- Reset values:
  - sec_bcd = 8'h00, min_bcd = START_MIN, hour_bcd = START_HOUR.
  - mode = 0, min_tick = 0, hour_tick = 0, pm = 0.

## Timing
- All outputs are registered.
- An input pulse in cycle N is reflected on outputs at the in_clk edge ending cycle N, i.e. visible in cycle N+1.
- min_tick and hour_tick are high for exactly the one cycle in which the new value appears.
- A full carry chain (seconds, minutes, hours) resolves in that same single cycle. There is no ripple across cycles.
- Reset assertion takes effect immediately, independent of in_clk, and aborts set mode mid-edit. Deassertion is synchronised by the upstream reset logic.
- Back-to-back sec_tick on consecutive cycles is legal and counts twice.

## Configuration
- H12_EN defined:
  - hour_bcd counts 12, 01..11; 12 follows 11, and 01 follows 12.
  - pm toggles on the RUN transition 11:59:59 -> 12:00:00.
  - In SET_HOUR, inc_btn steps hours 11->12 and toggles pm, and also steps 12->01 without toggling.
  - START_HOUR 8'h00 loads as 8'h12; pm resets to 0.
- H12_EN undefined: hour_bcd counts 00..23 and pm is tied to 0.

## Structure
- Shared package clock_pkg holds:
  - the mode enum (RUN, SET_HOUR, SET_MIN);
  - BCD limit constants 8'h59, 8'h23, 8'h12;
  - the H12_EN-dependent hour range constants.
- One sub-module, bcd_mod_counter: a two-digit BCD counter with parameters for max value and wrap value. It has inc and load inputs and a wrap output. It is instantiated three times, for seconds, minutes and hours.

## Test plan
- Reset with defaults, then 61 sec_tick pulses -> sec_bcd 8'h01, min_bcd 8'h01; one min_tick pulse after the 60th tick.
- Preload 23:59:58 via set mode, then two ticks -> 23:59:59, then 00:00:00; min_tick and hour_tick both pulse in the same cycle.
- SET_HOUR, then 25 inc_btn -> hour_bcd 8'h01 with min and sec unchanged; 100 sec_tick during set mode leave time unchanged.
- mode_btn and inc_btn in the same cycle while in SET_HOUR -> mode becomes SET_MIN and hour is unchanged.
- Exit SET_MIN with sec_bcd at 8'h37 -> sec_bcd 8'h00, mode 0; rst asserted mid-SET_MIN -> immediate reset values.
- H12_EN: 11:59:59 pm=0, then one tick -> 12:00:00 pm=1; from 12:59:59, one tick -> 01:00:00 with pm unchanged.
